led_fade_driver: RTL and testbench
==================================

Name: led_fade_driver

Overview:
- Downstream consumer of the Avalon-MM LED register's 5-bit `leds` output.
- Turns each static on/off bit into a PWM-driven physical LED with programmable brightness, linear fade-in/fade-out and an optional global blink.
- Sits between the LED register block and the board LED pins.
- Configuration inputs come from spare bits of the same register or from a sibling register.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz.
- TICK_HZ, 1000, fade/blink tick rate in Hz. The prescaler terminal count is CLK_HZ/TICK_HZ-1; CLK_HZ/TICK_HZ must be >= 2.
- PWM_BITS, 8, width of the PWM counter, levels, brightness and fade step.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-low reset; 0 = reset asserted.
- leds_in  in  5  requested on/off pattern, one bit per LED.
- brightness  in  PWM_BITS  target level for lit LEDs.
- fade_step  in  PWM_BITS  level change per tick; 0 = instant.
- blink_half_ticks  in  16  ticks per blink half-period; 0 = blink disabled.
- led_out  out  5  PWM drive to pins; 1 = LED lit.
- blink_phase  out  1  current blink phase; 1 = on phase.
- busy  out  1  1 while any channel level differs from its target.

Behaviour:
- Reset, asynchronous on reset==0:
  - all levels = 0, pwm_cnt = 0, prescaler = 0, blink_cnt = 0.
  - sampled inputs = 0, led_out = 0, blink_phase = 1, busy = 0.
- Input stage: leds_in, brightness, fade_step and blink_half_ticks are registered every cycle. All logic below uses the registered copies, adding 1 cycle of latency.
- Prescaler:
  - Counts 0..CLK_HZ/TICK_HZ-1, then wraps.
  - `tick` is a 1-cycle pulse in the cycle the count equals the terminal value.
- PWM counter: PWM_BITS-wide, free-running, increments every cycle, wraps from 2^PWM_BITS-1 to 0.
- Blink:
  - If blink_half_ticks==0: blink_phase forced to 1 and blink_cnt held at 0.
  - Otherwise, on each tick: if blink_cnt==blink_half_ticks-1, then blink_cnt=0 and blink_phase toggles; else blink_cnt increments.
  - If blink_half_ticks changes to a value <= blink_cnt, the next tick takes the terminal branch (compare uses >=).
- Per-channel target: target[i] = (leds_in[i] & blink_phase) ? brightness : 0.
- Per-channel state, derived, reported only via busy:
  - OFF: level==0 and target==0.
  - RISING: level < target.
  - ON: level==target and level != 0.
  - FALLING: level > target.
- Level update:
  - If fade_step==0: level = target on every cycle, no tick needed.
  - Else on tick, RISING: level = min(level+fade_step, target). The sum is computed PWM_BITS+1 wide, so there is no wrap.
  - Else on tick, FALLING: level = max(level-fade_step, target). The difference is computed as a signed PWM_BITS+1 value, so there is no underflow.
  - A target change mid-fade reverses direction on the next tick from the current level; there is no restart.
- Output:
  - led_out[i] is registered as (level[i] > pwm_cnt).
  - Level 0: LED always off.
  - Level 2^PWM_BITS-1: LED on for 255 of every 256 cycles.
  - Duty = level/2^PWM_BITS.
- busy:
  - Registered OR over channels of (level != target).
  - Goes high the cycle after a target change becomes visible.
  - Goes low the cycle after the last channel reaches its target.
- Simultaneous tick and blink toggle: the target change takes effect for the following tick's level update. The level update in the toggle cycle uses the old target.

Optional Feature:
- Macro: LED_GAMMA_EN.
- Defined: the compare uses gamma = (level*level) >> PWM_BITS, a 2*PWM_BITS product truncated to PWM_BITS. led_out[i] = (gamma[i] > pwm_cnt). Level 255 gives gamma 254; level 15 gives gamma 0.
- Not defined: the compare uses level directly (linear). Fade and blink behaviour are identical in both builds.

Test Plan (CLK_HZ=1000, TICK_HZ=100, i.e. tick every 10 cycles):
1. Reset: hold reset=0 with random inputs → led_out=0, busy=0, blink_phase=1. Release and hold leds_in=0 → led_out stays 0 for 1000 cycles.
2. Instant mode: fade_step=0, brightness=128, leds_in=5'b00001 → level0=128 within 2 cycles. led_out[0] is high for exactly 128 of each 256-cycle window; other bits stay 0.
3. Fade up:
   - Stimulus: fade_step=16, brightness=255, leds_in=5'b10000.
   - level4 steps 16,32,…,240, then 255 on the 16th tick.
   - busy stays high throughout and drops 1 cycle after level4 reaches 255.
   - Then leds_in=0 → level4 falls 239,223,…,15,0 in 16 ticks.
4. Reversal: from level 96 while rising with step 32 to 255, set leds_in=0 → next tick level=64, then 32, then 0.
5. Blink: blink_half_ticks=3, fade_step=0, brightness=200, leds_in=5'b11111 → blink_phase toggles every 30 cycles. Levels alternate 200/0 in step with the phase. Set blink_half_ticks=0 → phase returns to 1 on the next cycle.
6. Async reset mid-fade: assert reset=0 between clock edges during a rise → led_out, busy and all levels clear immediately without waiting for a clk edge. Fade restarts from 0 after release.

Source files
------------

// File: rtl/led_fade_driver.sv
// Five-channel PWM LED driver with linear fade, global blink and brightness control.
// Optional perceptual gamma on the PWM compare is enabled by defining LED_GAMMA_EN.
module led_fade_driver #(
    parameter int CLK_HZ   = 50000000,
    parameter int TICK_HZ  = 1000,
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [4:0]          leds_in,
    input  logic [PWM_BITS-1:0] brightness,
    input  logic [PWM_BITS-1:0] fade_step,
    input  logic [15:0]         blink_half_ticks,
    output logic [4:0]          led_out,
    output logic                blink_phase,
    output logic                busy
);

    localparam int DIV     = CLK_HZ / TICK_HZ;
    localparam int PRESC_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_TC = PRESC_W'(DIV - 1);

    logic [4:0]                r_leds;
    logic [PWM_BITS-1:0]       r_bright;
    logic [PWM_BITS-1:0]       r_step;
    logic [15:0]               r_half;
    logic [PRESC_W-1:0]        r_presc;
    logic [PWM_BITS-1:0]       r_pwm_cnt;
    logic [15:0]               r_blink_cnt;
    logic                      r_blink_phase;
    logic [4:0][PWM_BITS-1:0]  r_level;
    logic [4:0]                r_led_out;
    logic                      r_busy;

    logic                      w_tick;
    logic [4:0][PWM_BITS-1:0]  w_target;
    logic [4:0][PWM_BITS-1:0]  w_level_nxt;
    logic [4:0][PWM_BITS:0]    w_sum;
    logic signed [PWM_BITS:0]  w_diff [5];
    logic [4:0][PWM_BITS-1:0]  w_cmp;
    logic [4:0]                w_led_nxt;
    logic                      w_busy_nxt;
    logic [15:0]               w_blink_cnt_nxt;
    logic                      w_blink_phase_nxt;

    function automatic logic [PWM_BITS-1:0] f_gamma(input logic [PWM_BITS-1:0] lvl);
        logic [2*PWM_BITS-1:0] prod;
        prod = {{PWM_BITS{1'b0}}, lvl} * {{PWM_BITS{1'b0}}, lvl};
        return prod[2*PWM_BITS-1:PWM_BITS];
    endfunction

    assign w_tick      = (r_presc == PRESC_TC);
    assign led_out     = r_led_out;
    assign blink_phase = r_blink_phase;
    assign busy        = r_busy;

    // Blink phase sequencing; a shrunk half-period takes the wrap branch on the next tick.
    always_comb begin
        w_blink_cnt_nxt   = r_blink_cnt;
        w_blink_phase_nxt = r_blink_phase;
        if (r_half == 16'd0) begin
            w_blink_cnt_nxt   = 16'd0;
            w_blink_phase_nxt = 1'b1;
        end else if (w_tick) begin
            if (r_blink_cnt >= (r_half - 16'd1)) begin
                w_blink_cnt_nxt   = 16'd0;
                w_blink_phase_nxt = ~r_blink_phase;
            end else begin
                w_blink_cnt_nxt   = r_blink_cnt + 16'd1;
            end
        end else begin
            w_blink_cnt_nxt   = r_blink_cnt;
        end
    end

    // Per-channel target, clamped fade arithmetic one bit wider than a level, and PWM compare.
    always_comb begin
        w_busy_nxt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            w_target[i]    = (r_leds[i] & r_blink_phase) ? r_bright : {PWM_BITS{1'b0}};
            w_sum[i]       = {1'b0, r_level[i]} + {1'b0, r_step};
            w_diff[i]      = $signed({1'b0, r_level[i]}) - $signed({1'b0, r_step});
            w_level_nxt[i] = r_level[i];
            if (r_step == {PWM_BITS{1'b0}}) begin
                w_level_nxt[i] = w_target[i];
            end else if (w_tick) begin
                if (r_level[i] < w_target[i]) begin
                    w_level_nxt[i] = (w_sum[i] >= {1'b0, w_target[i]}) ? w_target[i]
                                                                       : w_sum[i][PWM_BITS-1:0];
                end else if (r_level[i] > w_target[i]) begin
                    w_level_nxt[i] = (w_diff[i] <= $signed({1'b0, w_target[i]})) ? w_target[i]
                                                                                : w_diff[i][PWM_BITS-1:0];
                end else begin
                    w_level_nxt[i] = r_level[i];
                end
            end else begin
                w_level_nxt[i] = r_level[i];
            end
`ifdef LED_GAMMA_EN
            w_cmp[i] = f_gamma(r_level[i]);
`else
            w_cmp[i] = r_level[i];
`endif
            w_led_nxt[i] = (w_cmp[i] > r_pwm_cnt);
            w_busy_nxt   = w_busy_nxt | (r_level[i] != w_target[i]);
        end
    end

    // Input sampling, counters, channel levels and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_leds        <= 5'd0;
            r_bright      <= {PWM_BITS{1'b0}};
            r_step        <= {PWM_BITS{1'b0}};
            r_half        <= 16'd0;
            r_presc       <= {PRESC_W{1'b0}};
            r_pwm_cnt     <= {PWM_BITS{1'b0}};
            r_blink_cnt   <= 16'd0;
            r_blink_phase <= 1'b1;
            r_level       <= '0;
            r_led_out     <= 5'd0;
            r_busy        <= 1'b0;
        end else begin
            r_leds        <= leds_in;
            r_bright      <= brightness;
            r_step        <= fade_step;
            r_half        <= blink_half_ticks;
            r_presc       <= w_tick ? {PRESC_W{1'b0}} : (r_presc + PRESC_W'(1));
            r_pwm_cnt     <= r_pwm_cnt + PWM_BITS'(1);
            r_blink_cnt   <= w_blink_cnt_nxt;
            r_blink_phase <= w_blink_phase_nxt;
            r_level       <= w_level_nxt;
            r_led_out     <= w_led_nxt;
            r_busy        <= w_busy_nxt;
        end
    end

endmodule

// File: tb/tb_led_fade_driver.sv
// Scoreboard bench for led_fade_driver: a behavioural model predicts every output cycle,
// a monitor compares, and directed checks cover duty, blink period and async reset.
module tb_led_fade_driver;

    localparam int CLK_HZ  = 1000;
    localparam int TICK_HZ = 100;
    localparam int DIV     = CLK_HZ / TICK_HZ;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  leds_in;
    logic [7:0]  brightness;
    logic [7:0]  fade_step;
    logic [15:0] blink_half_ticks;
    logic [4:0]  led_out;
    logic        blink_phase;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0] led;
        logic       bsy;
        logic       ph;
    } exp_t;
    exp_t exp_q[$];

    // behavioural model state
    int m_presc, m_pwm, m_bcnt, m_phase, m_busy;
    int m_lvl [5];
    logic [4:0] m_out;
    int s_leds, s_bright, s_step, s_half;

    led_fade_driver #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .PWM_BITS(8)) dut (
        .clk              (clk),
        .reset            (reset),
        .leds_in          (leds_in),
        .brightness       (brightness),
        .fade_step        (fade_step),
        .blink_half_ticks (blink_half_ticks),
        .led_out          (led_out),
        .blink_phase      (blink_phase),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    function automatic int duty_level(input int l);
`ifdef LED_GAMMA_EN
        return (l * l) / 256;
`else
        return l;
`endif
    endfunction

    task automatic model_reset();
        m_presc = 0; m_pwm = 0; m_bcnt = 0; m_phase = 1; m_busy = 0; m_out = 5'd0;
        s_leds = 0; s_bright = 0; s_step = 0; s_half = 0;
        for (int i = 0; i < 5; i++) m_lvl[i] = 0;
    endtask

    task automatic model_step();
        int tgt [5];
        int nl [5];
        bit tick;
        int nb;
        if (!reset) begin
            model_reset();
        end else begin
            tick = (m_presc == DIV - 1);
            nb = 0;
            for (int i = 0; i < 5; i++) begin
                tgt[i] = (((s_leds >> i) & 1) == 1 && m_phase == 1) ? s_bright : 0;
                nl[i] = m_lvl[i];
                if (s_step == 0) nl[i] = tgt[i];
                else if (tick && m_lvl[i] < tgt[i]) nl[i] = (m_lvl[i] + s_step < tgt[i]) ? m_lvl[i] + s_step : tgt[i];
                else if (tick && m_lvl[i] > tgt[i]) nl[i] = (m_lvl[i] - s_step > tgt[i]) ? m_lvl[i] - s_step : tgt[i];
                m_out[i] = (duty_level(m_lvl[i]) > m_pwm);
                if (m_lvl[i] != tgt[i]) nb = 1;
            end
            m_busy = nb;
            if (s_half == 0) begin
                m_phase = 1; m_bcnt = 0;
            end else if (tick) begin
                if (m_bcnt >= s_half - 1) begin m_bcnt = 0; m_phase = 1 - m_phase; end
                else m_bcnt = m_bcnt + 1;
            end
            for (int i = 0; i < 5; i++) m_lvl[i] = nl[i];
            m_presc = tick ? 0 : m_presc + 1;
            m_pwm   = (m_pwm + 1) % 256;
            s_leds = int'(leds_in); s_bright = int'(brightness);
            s_step = int'(fade_step); s_half = int'(blink_half_ticks);
        end
        exp_q.push_back('{led: m_out, bsy: m_busy[0], ph: m_phase[0]});
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // monitor: outputs are valid every cycle, compare one cycle's prediction per edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty t=%0t", $time);
            end else begin
                e = exp_q.pop_front();
                if (led_out !== e.led || busy !== e.bsy || blink_phase !== e.ph) begin
                    errors++;
                    $display("FAIL outputs t=%0t got led_out=%b busy=%b phase=%b expected led_out=%b busy=%b phase=%b",
                             $time, led_out, busy, blink_phase, e.led, e.bsy, e.ph);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        cyc(3);
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(busy === 1'b0), 1);
    endtask

    initial begin
        int cnt, cnt_other, t0;
        logic p0;
        reset = 1'b0;
        leds_in = 5'($urandom); brightness = 8'($urandom);
        fade_step = 8'($urandom); blink_half_ticks = 16'($urandom_range(0, 5));

        // 1. reset with random inputs, then idle for 1000 cycles
        cyc(5);
        chk("reset_led_out", int'(led_out), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_phase", int'(blink_phase), 1);
        leds_in = 5'd0;
        reset = 1'b1;
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (led_out != 5'd0) cnt++;
        end
        chk("idle_dark_cycles", cnt, 0);

        // 2. instant mode duty
        fade_step = 8'd0; brightness = 8'd128; blink_half_ticks = 16'd0; leds_in = 5'b00001;
        cyc(4);
        cnt = 0; cnt_other = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (led_out[0]) cnt++;
            if (led_out[4:1] != 4'd0) cnt_other++;
        end
`ifdef LED_GAMMA_EN
        chk("instant_duty", cnt, 64);
`else
        chk("instant_duty", cnt, 128);
`endif
        chk("instant_other_dark", cnt_other, 0);
        leds_in = 5'd0;
        cyc(4);

        // 3. fade up to full and back down
        fade_step = 8'd16; brightness = 8'd255; leds_in = 5'b10000;
        cyc(3);
        chk("fade_up_busy", int'(busy), 1);
        wait_idle("fade_up_done", 400);
        leds_in = 5'd0;
        cyc(3);
        chk("fade_down_busy", int'(busy), 1);
        wait_idle("fade_down_done", 400);

        // 4. reversal mid-rise
        fade_step = 8'd32; leds_in = 5'b00100;
        cyc(31);
        leds_in = 5'd0;
        wait_idle("reversal_done", 300);

        // 5. blink period and disable
        blink_half_ticks = 16'd3; fade_step = 8'd0; brightness = 8'd200; leds_in = 5'b11111;
        p0 = blink_phase; t0 = 0;
        while (blink_phase === p0 && t0 < 100) begin @(negedge clk); t0++; end
        p0 = blink_phase; cnt = 0;
        while (blink_phase === p0 && cnt < 100) begin @(negedge clk); cnt++; end
        chk("blink_half_period", cnt, 30);
        cyc(45);
        blink_half_ticks = 16'd0;
        cyc(2);
        chk("blink_disable_phase", int'(blink_phase), 1);
        leds_in = 5'd0;
        cyc(3);

        // 6. async reset during a rise
        fade_step = 8'd8; brightness = 8'd255; leds_in = 5'b11111;
        cyc(60);
        #2 reset = 1'b0;
        #1;
        chk("async_led_out", int'(led_out), 0);
        chk("async_busy", int'(busy), 0);
        chk("async_phase", int'(blink_phase), 1);
        cyc(3);
        reset = 1'b1;
        cyc(5);
        chk("restart_busy", int'(busy), 1);
        wait_idle("restart_done", 500);

        // random segments
        for (int s = 0; s < 25; s++) begin
            leds_in          = 5'($urandom);
            brightness       = 8'($urandom);
            fade_step        = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 80));
            blink_half_ticks = 16'($urandom_range(0, 4));
            cyc($urandom_range(15, 150));
        end

        cyc(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
